// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-side logic.
package fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE = 12;
  localparam int unsigned SKID_DEPTH    = 3;
  localparam int unsigned PTR_W         = 2;

  typedef logic [DEF_DATA_SIZE-1:0] fifo_word_t;

  // Circular pointer advance over the skid buffer slots.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready output stream of the read-side streamer.
interface fifo_rd_streamer_if #(
  parameter int unsigned DATA_SIZE = 12
);
  logic                 rinc;
  logic                 rEmpty;
  logic [DATA_SIZE-1:0] rData;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    output rinc, m_data, m_valid, m_last,
    input  rEmpty, rData, m_ready
  );

  modport slave (
    input  rinc, m_data, m_valid, m_last,
    output rEmpty, rData, m_ready
  );
endinterface

// File: rtl/stream_skid_buf.sv
// Three-entry circular skid buffer with push, pop and clear.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [PTR_W-1:0]     occ,
  output logic [PTR_W-1:0]     count,
  output logic [DATA_SIZE-1:0] head
);

  logic [DATA_SIZE-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + PTR_W'(1);
        2'b01:   occ <= occ - PTR_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // count reports free slots, which is what the read-issue rule needs.
  assign count = PTR_W'(SKID_DEPTH) - occ;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the async FIFO read port into a valid/ready stream with burst framing;
// rinc never looks at m_ready, the skid buffer absorbs the two-cycle read loop.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_SIZE  = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                enable,
  input  logic                flush,
  fifo_rd_streamer_if.master  bus,
  output logic [CNT_SIZE-1:0] words_read
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic                 inflight;
  logic [BEAT_W-1:0]    beat;
  logic [PTR_W-1:0]     occ;
  logic [PTR_W-1:0]     free_cnt;
  logic [DATA_SIZE-1:0] head;
  logic                 hs;
  logic                 last_beat;

  stream_skid_buf #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .rclk      (rclk),
    .rrst      (rrst),
    .clear     (flush),
    .push      (inflight && !flush),
    .push_data (bus.rData),
    .pop       (hs),
    .occ       (occ),
    .count     (free_cnt),
    .head      (head)
  );

  // Issue only when the buffer can hold this word on top of any in-flight one.
  assign bus.rinc = enable && !bus.rEmpty && !flush && !rrst
                    && (PTR_W'(inflight) < free_cnt);

  assign hs          = bus.m_valid && bus.m_ready && !flush;
  assign last_beat   = (beat == BEAT_W'(BURST_LEN - 1));
  assign bus.m_valid = (occ != '0);
  assign bus.m_last  = bus.m_valid && last_beat;
  assign bus.m_data  = head;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight   <= 1'b0;
      beat       <= '0;
      words_read <= '0;
    end else if (flush) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= bus.rinc;
      if (hs) begin
        beat       <= last_beat ? '0 : beat + BEAT_W'(1);
        words_read <= words_read + CNT_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench: FIFO model feeds two streamers (burst 16 and burst 4 / 4-bit counter).
module tb_fifo_rd_streamer;

  localparam int unsigned DW = 12;

  typedef struct {
    logic [DW-1:0] data;
    logic          last16;
    logic          last4;
  } exp_t;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        enable;
  logic        flush;
  logic [15:0] wr16;
  logic [3:0]  wr4;

  fifo_rd_streamer_if #(.DATA_SIZE(DW)) bus16 ();
  fifo_rd_streamer_if #(.DATA_SIZE(DW)) bus4 ();

  assign bus4.rEmpty  = bus16.rEmpty;
  assign bus4.rData   = bus16.rData;
  assign bus4.m_ready = bus16.m_ready;

  fifo_rd_streamer #(.DATA_SIZE(DW)) u_dut16 (
    .rclk(rclk), .rrst(rrst), .enable(enable), .flush(flush),
    .bus(bus16.master), .words_read(wr16)
  );

  fifo_rd_streamer #(.DATA_SIZE(DW), .BURST_LEN(4), .CNT_SIZE(4)) u_dut4 (
    .rclk(rclk), .rrst(rrst), .enable(enable), .flush(flush),
    .bus(bus4.master), .words_read(wr4)
  );

  always #5 rclk = ~rclk;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int delivered = 0;
  int pos = 0;
  int rinc_cnt = 0;
  int first_rinc_cyc = -1;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  bit gate_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    exp_t e;
    fifo_q.push_back(d);
    e.data   = d;
    e.last16 = ((pos % 16) == 15);
    e.last4  = ((pos % 4) == 3);
    pos++;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  always @(posedge rclk) cyc++;

  // Async FIFO read-port model: registered empty, data updates after a read edge.
  initial begin
    bit do_pop;
    bit gate_ph;
    gate_ph = 1'b0;
    bus16.rEmpty = 1'b1;
    bus16.rData  = '0;
    forever begin
      @(negedge rclk);
      do_pop = bus16.rinc;
      if (do_pop) begin
        rinc_cnt++;
        if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
      end
      @(posedge rclk);
      #1;
      if (do_pop && fifo_q.size() > 0) bus16.rData = fifo_q.pop_front();
      gate_ph = ~gate_ph;
      bus16.rEmpty = (fifo_q.size() == 0) || (gate_mode && gate_ph);
    end
  end

  // Monitor: compare each handshake against the scoreboard head.
  initial begin
    exp_t          e;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rclk);
      if (rrst) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (32'(u_dut16.occ) + 32'(u_dut16.inflight) > 3) begin
          errors++;
          $display("FAIL occ_inflight_bound: got %0d expected <=3",
                   32'(u_dut16.occ) + 32'(u_dut16.inflight));
        end
        if (prev_stall) check("m_data_hold", 32'(bus16.m_data), 32'(prev_data));
        if (!flush && bus16.m_valid && bus16.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h expected none", bus16.m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 32'(bus16.m_data), 32'(e.data));
            check("m_last16", 32'(bus16.m_last), 32'(e.last16));
            check("m_last4", 32'(bus4.m_last), 32'(e.last4));
            delivered++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
          end
        end
        prev_stall = bus16.m_valid && !bus16.m_ready && !flush;
        prev_data  = bus16.m_data;
      end
    end
  end

  initial begin
    int r0;
    int d0;
    rrst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    bus16.m_ready = 1'b0;
    step(3);
    check("rst_m_valid", 32'(bus16.m_valid), 0);
    check("rst_m_last", 32'(bus16.m_last), 0);
    check("rst_m_data", 32'(bus16.m_data), 0);
    check("rst_words_read", 32'(wr16), 0);
    check("rst_rinc", 32'(bus16.rinc), 0);

    rrst = 1'b0;
    enable = 1'b1;
    bus16.m_ready = 1'b1;
    step(2);

    // Full burst at line rate.
    for (int i = 1; i <= 16; i++) write_word(DW'(i));
    wait_drain(200);
    step(2);
    check("t1_latency", 32'(first_hs_cyc - first_rinc_cyc), 2);
    check("t1_rate", 32'(last_hs_cyc - first_hs_cyc), 15);
    check("t1_words_read16", 32'(wr16), 16);
    check("t1_words_read4", 32'(wr4), 0);

    // Back-pressure: exactly three reads then hold.
    bus16.m_ready = 1'b0;
    r0 = rinc_cnt;
    for (int i = 1; i <= 8; i++) write_word(DW'(i));
    step(12);
    check("t2_rinc_pulses", 32'(rinc_cnt - r0), 3);
    check("t2_occ", 32'(u_dut16.occ), 3);
    check("t2_rinc_low", 32'(bus16.rinc), 0);
    check("t2_head", 32'(bus16.m_data), 32'h001);
    step(3);
    check("t2_head_hold", 32'(bus16.m_data), 32'h001);
    bus16.m_ready = 1'b1;
    wait_drain(200);
    step(2);
    check("t2_words_read16", 32'(wr16), 24);
    check("t2_words_read4", 32'(wr4), 8);

    // Random ready, flush after nine words, framing restarts.
    d0 = delivered;
    for (int i = 0; i < 10; i++) write_word(DW'(12'h101 + i));
    bus16.m_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 300; i++) begin
      step();
      if (delivered - d0 >= 9) break;
      bus16.m_ready = 1'($urandom_range(0, 1));
    end
    bus16.m_ready = 1'b0;
    check("t3_nine_delivered", 32'(delivered - d0), 9);
    step(6);
    flush = 1'b1;
    exp_q.delete();
    pos = 0;
    step();
    flush = 1'b0;
    check("t3_flush_valid", 32'(bus16.m_valid), 0);
    check("t3_flush_words_read16", 32'(wr16), 33);
    check("t3_flush_words_read4", 32'(wr4), 1);
    bus16.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(DW'(12'h201 + i));
    wait_drain(100);
    step(2);
    check("t3_words_read16", 32'(wr16), 37);
    check("t3_words_read4", 32'(wr4), 5);

    // rEmpty toggling with random ready.
    gate_mode = 1'b1;
    for (int i = 0; i < 12; i++) write_word(DW'(12'h301 + i));
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      bus16.m_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("t4_drained", exp_q.size(), 0);
    gate_mode = 1'b0;
    bus16.m_ready = 1'b1;
    step(3);
    check("t4_words_read16", 32'(wr16), 49);
    check("t4_words_read4", 32'(wr4), 1);

    // Reset mid-operation with occ=2, inflight=1.
    bus16.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(DW'(12'h401 + i));
    for (int i = 0; i < 20; i++) begin
      step();
      if (u_dut16.occ == 2'd2 && u_dut16.inflight) break;
    end
    check("t5_occ_before_rst", 32'(u_dut16.occ), 2);
    check("t5_inflight_before_rst", 32'(u_dut16.inflight), 1);
    rrst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    pos = 0;
    #1;
    check("t5_rinc_in_rst", 32'(bus16.rinc), 0);
    step();
    check("t5_m_valid", 32'(bus16.m_valid), 0);
    check("t5_words_read16", 32'(wr16), 0);
    check("t5_words_read4", 32'(wr4), 0);
    check("t5_rinc_still_rst", 32'(bus16.rinc), 0);
    check("t5_m_data", 32'(bus16.m_data), 0);
    step();
    rrst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
